// File: rtl/apb_master_arb_pkg.sv
// Shared types and widths for the two-master APB arbiter.
package apb_master_arb_pkg;

  localparam int unsigned ADDR_W = 40;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO_W   = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

endpackage

// File: rtl/apb_arb_rr.sv
// Two-way round-robin pick; on a tie the port that was not granted last wins.
module apb_arb_rr (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/apb_master_arb.sv
// Arbitrates two requesters onto one APB master port with an ACCESS-phase timeout.
module apb_master_arb
  import apb_master_arb_pkg::*;
#(
  parameter logic [TO_W-1:0] TO_CYC = 8'd255
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] arb_xx_paddr,
  output logic              arb_xx_psel,
  output logic              arb_xx_penable,
  output logic              arb_xx_pwrite,
  output logic [DATA_W-1:0] arb_xx_pwdata,
  input  logic [DATA_W-1:0] xx_arb_prdata,
  input  logic              xx_arb_pready
);

  localparam logic [TO_W-1:0] ToLast = TO_CYC - 8'd1;

  state_e            state_q, state_d;
  logic              last_gnt_q;
  logic              cur_q;
  logic [TO_W-1:0]   cnt_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [1:0]        done_q, err_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [1:0] gnt;
  logic       grant;
  logic       to_hit;
  logic       access_exit;
  logic       timeout;

  apb_arb_rr u_rr (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

  // The done cycle doubles as a dead cycle so a still-held req is not regranted.
  assign grant  = (state_q == StIdle) && (done_q == 2'b00) && (gnt != 2'b00);
  assign to_hit = (TO_CYC != '0) && (cnt_q == ToLast);

  always_comb begin
    state_d     = state_q;
    access_exit = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      StIdle:  if (grant) state_d = StSetup;
      StSetup: state_d = StAccess;
      StAccess: begin
        if (xx_arb_pready) begin
          state_d     = StIdle;
          access_exit = 1'b1;
        end else if (to_hit) begin
          state_d     = StIdle;
          access_exit = 1'b1;
          timeout     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      cur_q      <= 1'b0;
      cnt_q      <= '0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        cur_q      <= gnt[1];
        last_gnt_q <= gnt[1];
        paddr_q    <= gnt[1] ? m1_addr  : m0_addr;
        pwrite_q   <= gnt[1] ? m1_write : m0_write;
        pwdata_q   <= gnt[1] ? m1_wdata : m0_wdata;
      end
      if (state_q == StSetup) begin
        cnt_q <= '0;
      end else if ((state_q == StAccess) && !xx_arb_pready) begin
        cnt_q <= cnt_q + 1'b1;
      end
      done_q <= 2'b00;
      err_q  <= 2'b00;
      if (access_exit) begin
        done_q[cur_q] <= 1'b1;
        err_q[cur_q]  <= timeout;
        if (!pwrite_q) begin
          if (cur_q) rdata1_q <= timeout ? '0 : xx_arb_prdata;
          else       rdata0_q <= timeout ? '0 : xx_arb_prdata;
        end
      end
    end
  end

  assign arb_xx_paddr   = paddr_q;
  assign arb_xx_pwrite  = pwrite_q;
  assign arb_xx_pwdata  = pwdata_q;
  assign arb_xx_psel    = (state_q != StIdle);
  assign arb_xx_penable = (state_q == StAccess);

  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Scenario bench for apb_master_arb; completions are checked against a queue of expectations.
module tb_apb_master_arb;

  localparam logic [7:0] TO_CYC = 8'd4;

  logic        pclk, prst;
  logic        m0_req, m0_write, m0_done, m0_err;
  logic [39:0] m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_write, m1_done, m1_err;
  logic [39:0] m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic [39:0] paddr;
  logic        psel, penable, pwrite, pready;
  logic [31:0] pwdata, prdata;

  apb_master_arb #(.TO_CYC(TO_CYC)) dut (
    .pclk           (pclk),
    .prst           (prst),
    .m0_req         (m0_req),
    .m0_addr        (m0_addr),
    .m0_write       (m0_write),
    .m0_wdata       (m0_wdata),
    .m0_done        (m0_done),
    .m0_err         (m0_err),
    .m0_rdata       (m0_rdata),
    .m1_req         (m1_req),
    .m1_addr        (m1_addr),
    .m1_write       (m1_write),
    .m1_wdata       (m1_wdata),
    .m1_done        (m1_done),
    .m1_err         (m1_err),
    .m1_rdata       (m1_rdata),
    .arb_xx_paddr   (paddr),
    .arb_xx_psel    (psel),
    .arb_xx_penable (penable),
    .arb_xx_pwrite  (pwrite),
    .arb_xx_pwdata  (pwdata),
    .xx_arb_prdata  (prdata),
    .xx_arb_pready  (pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_rd[2];

  task automatic push(input logic port, input logic err, input logic is_read,
                      input logic [31:0] rd);
    exp_t e;
    if (is_read) model_rd[port] = rd;
    e.port  = port;
    e.err   = err;
    e.rdata = model_rd[port];
    sb.push_back(e);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge pclk) begin
    if (!prst && (m0_done || m1_done)) begin
      tests++;
      if (m0_done && m1_done) begin
        fails++;
        $display("FAIL done_both: m0_done=1 m1_done=1, required one port only");
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: m0_done=%0b m1_done=%0b, required none", m0_done,
                 m1_done);
      end else begin
        mon_e = sb.pop_front();
        if ({m1_done, (m1_done ? m1_err : m0_err), (m1_done ? m1_rdata : m0_rdata)} !==
            {mon_e.port, mon_e.err, mon_e.rdata}) begin
          fails++;
          $display("FAIL completion: port=%0b err=%0b rdata=%h, required port=%0b err=%0b rdata=%h",
                   m1_done, (m1_done ? m1_err : m0_err), (m1_done ? m1_rdata : m0_rdata),
                   mon_e.port, mon_e.err, mon_e.rdata);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge pclk); #1;
    prst = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b0;
    model_rd[0] = '0;
    model_rd[1] = '0;
  endtask

  task automatic test_reset();
    prst = 1'b1;
    {m0_req, m0_write, m1_req, m1_write, pready} = '0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; prdata = '0;
    model_rd[0] = '0;
    model_rd[1] = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    tests++;
    if ({psel, penable, pwrite, paddr, pwdata} !== '0) begin
      fails++;
      $display("FAIL reset_bus: psel=%0b penable=%0b pwrite=%0b paddr=%h pwdata=%h, required 0",
               psel, penable, pwrite, paddr, pwdata);
    end
    tests++;
    if ({m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_masters: done=%0b%0b err=%0b%0b rdata=%h/%h, required 0", m0_done,
               m1_done, m0_err, m1_err, m0_rdata, m1_rdata);
    end
    prst = 1'b0;
  endtask

  task automatic test_write();
    @(posedge pclk); #1;
    m0_req = 1'b1; m0_write = 1'b1;
    m0_addr = 40'h00_1000_0000; m0_wdata = 32'hA5A5_5A5A; pready = 1'b1;
    push(1'b0, 1'b0, 1'b0, '0);
    @(negedge pclk);
    tests++;
    if (psel !== 1'b0) begin
      fails++; $display("FAIL write_t0_psel: psel=%0b, required 0", psel);
    end
    @(negedge pclk);
    tests++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {2'b10, 1'b1, 40'h00_1000_0000, 32'hA5A5_5A5A})
    begin
      fails++;
      $display("FAIL write_t1_setup: psel=%0b penable=%0b pwrite=%0b paddr=%h pwdata=%h",
               psel, penable, pwrite, paddr, pwdata);
    end
    @(negedge pclk);
    tests++;
    if ({psel, penable} !== 2'b11) begin
      fails++; $display("FAIL write_t2_access: psel=%0b penable=%0b, required 1 1", psel, penable);
    end
    @(negedge pclk);
    tests++;
    if ({m0_done, m0_err, psel} !== 3'b100) begin
      fails++;
      $display("FAIL write_t3_done: done=%0b err=%0b psel=%0b, required 1 0 0", m0_done, m0_err,
               psel);
    end
    @(posedge pclk); #1;
    m0_req = 1'b0; m0_write = 1'b0;
  endtask

  task automatic test_round_robin();
    int   dc[3];
    logic dp[3];
    int   n = 0;
    int   cyc = 0;
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_write = 1'b0; m1_write = 1'b0;
    m0_addr = 40'h00_0000_0100; m1_addr = 40'h00_0000_0200;
    pready = 1'b1; prdata = 32'h600D_0001;
    push(1'b0, 1'b0, 1'b1, 32'h600D_0001);
    push(1'b1, 1'b0, 1'b1, 32'h600D_0001);
    push(1'b0, 1'b0, 1'b1, 32'h600D_0001);
    while (n < 3 && cyc < 20) begin
      @(negedge pclk);
      if (m0_done || m1_done) begin
        dc[n] = cyc; dp[n] = m1_done; n++;
      end
      cyc++;
    end
    @(posedge pclk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    tests++;
    if (n != 3) begin
      fails++; $display("FAIL rr_count: dones=%0d, required 3", n);
    end else begin
      tests++;
      if ({dp[0], dp[1], dp[2]} !== 3'b010) begin
        fails++; $display("FAIL rr_order: ports=%0b%0b%0b, required 010", dp[0], dp[1], dp[2]);
      end
      tests++;
      if (dc[0] != 3 || dc[1] - dc[0] != 4 || dc[2] - dc[1] != 4) begin
        fails++;
        $display("FAIL rr_spacing: done cycles %0d %0d %0d, required 3 7 11", dc[0], dc[1], dc[2]);
      end
    end
  endtask

  task automatic test_wait_read();
    int acc = 0;
    int cyc = 0;
    logic seen = 1'b0;
    pready = 1'b0; prdata = 32'hDEAD_BEEF;
    m1_req = 1'b1; m1_write = 1'b0; m1_addr = 40'h00_0000_0300;
    push(1'b1, 1'b0, 1'b1, 32'h1234_5678);
    while (!seen && cyc < 20) begin
      @(posedge pclk); #1;
      if (psel && penable) begin
        if (acc == 3) begin
          pready = 1'b1; prdata = 32'h1234_5678; seen = 1'b1;
        end else begin
          acc++;
        end
      end
      cyc++;
    end
    @(posedge pclk); #1;
    pready = 1'b0; prdata = 32'hDEAD_BEEF;
    tests++;
    if (!seen || m1_done !== 1'b1) begin
      fails++;
      $display("FAIL wait_done_latency: m1_done=%0b ready_seen=%0b, required 1 1", m1_done, seen);
    end
    tests++;
    if (m0_rdata !== 32'h600D_0001) begin
      fails++; $display("FAIL wait_m0_rdata_hold: m0_rdata=%h, required 600d0001", m0_rdata);
    end
    @(posedge pclk); #1;
    m1_req = 1'b0;
  endtask

  task automatic test_timeout();
    int   acc = 0;
    int   cyc = 0;
    logic got = 1'b0;
    pready = 1'b0; prdata = 32'hFFFF_FFFF;
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 40'h00_0000_0400;
    push(1'b0, 1'b1, 1'b1, 32'h0);
    while (!got && cyc < 30) begin
      @(negedge pclk);
      if (psel && penable) acc++;
      if (m0_done) got = 1'b1;
      cyc++;
    end
    tests++;
    if (!got || acc != 4 || psel !== 1'b0) begin
      fails++;
      $display("FAIL timeout: done=%0b access_cycles=%0d psel=%0b, required 1 4 0", got, acc,
               psel);
    end
    @(posedge pclk); #1;
    m0_req = 1'b0;
  endtask

  task automatic test_reset_abort();
    int   cyc = 0;
    int   ndone = 0;
    logic got = 1'b0;
    pready = 1'b0;
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 40'h00_0000_0500;
    while (!(psel && penable) && cyc < 10) begin
      @(negedge pclk);
      cyc++;
    end
    prst = 1'b1;
    #1;
    tests++;
    if ({psel, penable} !== 2'b00) begin
      fails++;
      $display("FAIL abort_bus: psel=%0b penable=%0b, required 0 0", psel, penable);
    end
    m0_req = 1'b0;
    @(negedge pclk);
    prst = 1'b0;
    model_rd[0] = '0;
    model_rd[1] = '0;
    repeat (6) begin
      @(negedge pclk);
      if (m0_done || m1_done) ndone++;
    end
    tests++;
    if (ndone != 0) begin
      fails++; $display("FAIL abort_no_done: dones=%0d, required 0", ndone);
    end
    @(posedge pclk); #1;
    m0_req = 1'b1; m1_req = 1'b1; m1_write = 1'b0; pready = 1'b1; prdata = 32'hABCD_0000;
    push(1'b0, 1'b0, 1'b1, 32'hABCD_0000);
    push(1'b1, 1'b0, 1'b1, 32'hABCD_0000);
    cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge pclk);
      if (m0_done || m1_done) got = 1'b1;
      cyc++;
    end
    tests++;
    if (!got || m0_done !== 1'b1) begin
      fails++;
      $display("FAIL abort_tie_m0: m0_done=%0b m1_done=%0b, required 1 0", m0_done, m1_done);
    end
    @(posedge pclk); #1;
    m0_req = 1'b0;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge pclk);
      if (m1_done) got = 1'b1;
      cyc++;
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL abort_then_m1: m1_done=0, required 1");
    end
    @(posedge pclk); #1;
    m1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_wait_read();
    test_timeout();
    test_reset_abort();
    repeat (3) @(negedge pclk);
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL sb_drain: %0d completions outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 SHALL have parameter TO_CYC, default 8'd255, meaning the maximum number of ACCESS cycles before timeout; 0 disables the timeout.
REQ-002 SHALL have port pclk  in  1  peripheral clock (per_clk domain); all flops on its rising edge.
REQ-003 SHALL have port prst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mN_req (N=0,1)  in  1  transfer request, held until mN_done.
REQ-005 SHALL have port mN_addr  in  40  transfer address, stable while req is high.
REQ-006 SHALL have port mN_write  in  1  1=write, 0=read.
REQ-007 SHALL have port mN_wdata  in  32  write data.
REQ-008 SHALL have port mN_done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port mN_err  out  1  timeout flag, valid with done.
REQ-010 SHALL have port mN_rdata  out  32  read data, updated on read completion only.
REQ-011 SHALL have port arb_xx_paddr  out  40  shared APB address to apb_bridge decode.
REQ-012 SHALL have port arb_xx_psel  out  1  transfer active (SETUP and ACCESS).
REQ-013 SHALL have port arb_xx_penable  out  1  ACCESS phase.
REQ-014 SHALL have port arb_xx_pwrite  out  1  direction.
REQ-015 SHALL have port arb_xx_pwdata  out  32  write data.
REQ-016 SHALL have port xx_arb_prdata  in  32  muxed slave read data.
REQ-017 SHALL have port xx_arb_pready  in  1  slave ready; tie 1 for zero-wait slaves.

Function
REQ-018 SHALL implement FSM IDLE, SETUP, ACCESS.
REQ-019 IDLE -> SETUP when any mN_req is high and no mN_done is high this cycle; otherwise IDLE -> IDLE.
REQ-020 SETUP -> ACCESS unconditionally after 1 cycle.
REQ-021 ACCESS -> IDLE on pready=1 or timeout; otherwise ACCESS -> ACCESS.
REQ-022 Arbitration in IDLE: if one request is pending, grant it; if both, grant the port not in last_gnt; last_gnt updates on grant.
REQ-023 paddr/pwrite/pwdata SHALL be registered from the granted port at the IDLE->SETUP edge and held until the next grant.
REQ-024 psel=1 in SETUP and ACCESS; penable=1 in ACCESS only; both 0 in IDLE.
REQ-025 Timeout counter: cleared in SETUP, incremented each ACCESS cycle with pready=0; when TO_CYC!=0 and count reaches TO_CYC, the transfer terminates.
REQ-026 mN_done SHALL be registered: high exactly one cycle, the cycle after the ACCESS exit edge, on the granted port only.
REQ-027 On pready completion err=0; on timeout err=1, and a read returns rdata=32'h0.
REQ-028 On read completion, mN_rdata SHALL be loaded with prdata sampled in the pready cycle; on write, mN_rdata SHALL hold.
REQ-029 Minimum transfer period SHALL be 4 cycles (arbitrate, SETUP, ACCESS, done/dead).
REQ-030 Requester deasserting req mid-transfer SHALL NOT abort the transfer; done SHALL still pulse.
REQ-031 pready in IDLE or SETUP SHALL be ignored.

Reset
REQ-032 prst SHALL asynchronously force IDLE, all outputs 0 (paddr, pwdata, rdata, done, err, psel, penable, pwrite), last_gnt=1 (m0 wins the first tie), counter=0.
REQ-033 A transfer aborted by reset SHALL produce no done pulse after reset release.

Structure
REQ-034 Package apb_master_arb_pkg SHALL hold the state enum and the constants ADDR_W=40, DATA_W=32, TO_W=8.
REQ-035 The 2-way round-robin pick SHALL be the sub-module apb_arb_rr (inputs req[1:0], last_gnt; output gnt[1:0], one-hot or zero).

Verification
REQ-036 m0 write 0x1000_0000/0xA5A5_5A5A, pready=1 -> psel at T1, penable at T2, m0_done at T3 with err=0, and the pwdata bus shows the data.
REQ-037 m0 and m1 reads pending together from reset -> m0 served first, then m1; with both held, grants alternate m0,m1,m0; each done arrives 4 cycles apart.
REQ-038 m1 read with pready low 3 ACCESS cycles, prdata=0x1234_5678 -> m1_done 1 cycle after pready with rdata=0x1234_5678, and m0_rdata unchanged.
REQ-039 TO_CYC=4 with pready stuck at 0 -> ACCESS lasts 4 cycles, then m0_done=1, m0_err=1, rdata=0, and the FSM returns to IDLE.
REQ-040 prst pulsed during ACCESS -> psel/penable 0 immediately, no done follows, and a subsequent tie grants m0.
